interconnect_link_model: RTL and testbench

Parametrised, bidirectional, multi-channel model of an inter-FPGA link between an upstream (root-side) and a downstream (leaf-side) decoder controller. Each channel direction buffers flits in a FIFO and releases each flit exactly LATENCY cycles after acceptance. Releases are throttled to at most one flit per GAP+1 cycles. Sideband status bits (message-flying, odd-clusters) travel downstream→upstream through a LATENCY-deep delay line, so the termination logic sees link-consistent timing.

---
 rtl/interconnect_link_model.sv | 177 +++++++++++++++++
 tb/tb_interconnect_link_model.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interconnect_link_model.sv
// Bidirectional multi-channel inter-FPGA link model: per-channel latency FIFOs with release throttle
// and a delayed sideband path. Optional `LINK_STATS_EN adds saturating flit/stall counters.
module interconnect_link_model #(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned GAP      = 0,
    parameter int unsigned TS_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] upstream_fifo_in_data,
    input  logic [CHANNELS-1:0]       upstream_fifo_in_valid,
    output logic [CHANNELS-1:0]       upstream_fifo_in_ready,
    output logic [WIDTH*CHANNELS-1:0] downstream_fifo_out_data,
    output logic [CHANNELS-1:0]       downstream_fifo_out_valid,
    input  logic [CHANNELS-1:0]       downstream_fifo_out_ready,
    input  logic [WIDTH*CHANNELS-1:0] downstream_fifo_in_data,
    input  logic [CHANNELS-1:0]       downstream_fifo_in_valid,
    output logic [CHANNELS-1:0]       downstream_fifo_in_ready,
    output logic [WIDTH*CHANNELS-1:0] upstream_fifo_out_data,
    output logic [CHANNELS-1:0]       upstream_fifo_out_valid,
    input  logic [CHANNELS-1:0]       upstream_fifo_out_ready,
    input  logic [CHANNELS-1:0]       downstream_has_message_flying,
    input  logic [CHANNELS-1:0]       downstream_has_odd_clusters,
    output logic [CHANNELS-1:0]       upstream_has_message_flying,
    output logic [CHANNELS-1:0]       upstream_has_odd_clusters,
    output logic                      link_busy
`ifdef LINK_STATS_EN
    ,
    output logic [31:0]               stat_flits_down,
    output logic [31:0]               stat_flits_up,
    output logic [31:0]               stat_stall_cycles
`endif
);

    localparam int unsigned NQ = 2 * CHANNELS;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    generate
        if (LATENCY == 0) begin : g_wire
            assign downstream_fifo_out_data    = upstream_fifo_in_data;
            assign downstream_fifo_out_valid   = upstream_fifo_in_valid;
            assign upstream_fifo_in_ready      = downstream_fifo_out_ready;
            assign upstream_fifo_out_data      = downstream_fifo_in_data;
            assign upstream_fifo_out_valid     = downstream_fifo_in_valid;
            assign downstream_fifo_in_ready    = upstream_fifo_out_ready;
            assign upstream_has_message_flying = downstream_has_message_flying;
            assign upstream_has_odd_clusters   = downstream_has_odd_clusters;
            assign link_busy                   = 1'b0;
        end else begin : g_link
            logic [TS_W-1:0]  now;
            logic [WIDTH-1:0] q_in_data  [NQ];
            logic [WIDTH-1:0] q_out_data [NQ];
            logic [NQ-1:0]    q_in_valid, q_in_ready, q_out_valid, q_out_ready, q_busy;
            logic [2*CHANNELS-1:0] sb_pipe [LATENCY];

            // Queues 0..CHANNELS-1 carry traffic down, the rest carry traffic up.
            assign q_in_valid  = {downstream_fifo_in_valid, upstream_fifo_in_valid};
            assign q_out_ready = {upstream_fifo_out_ready, downstream_fifo_out_ready};
            assign upstream_fifo_in_ready    = q_in_ready[CHANNELS-1:0];
            assign downstream_fifo_in_ready  = q_in_ready[NQ-1:CHANNELS];
            assign downstream_fifo_out_valid = q_out_valid[CHANNELS-1:0];
            assign upstream_fifo_out_valid   = q_out_valid[NQ-1:CHANNELS];
            assign link_busy = |q_busy;

            for (genvar c = 0; c < CHANNELS; c++) begin : g_map
                assign q_in_data[c]            = upstream_fifo_in_data[c*WIDTH +: WIDTH];
                assign q_in_data[c+CHANNELS]   = downstream_fifo_in_data[c*WIDTH +: WIDTH];
                assign downstream_fifo_out_data[c*WIDTH +: WIDTH] = q_out_data[c];
                assign upstream_fifo_out_data[c*WIDTH +: WIDTH]   = q_out_data[c+CHANNELS];
            end

            always_ff @(posedge clk) begin
                if (reset) now <= '0;
                else        now <= now + TS_W'(1);
            end

            for (genvar q = 0; q < NQ; q++) begin : g_q
                logic [WIDTH-1:0] data_mem [DEPTH];
                logic [TS_W-1:0]  ts_mem   [DEPTH];
                logic [AW:0]      wr_ptr, rd_ptr;
                logic [TS_W-1:0]  age;
                logic [GW-1:0]    gap_cnt;
                logic             head_eligible, empty, full, age_ok, push, pop;

                assign empty  = (wr_ptr == rd_ptr);
                assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
                assign age    = now - ts_mem[rd_ptr[AW-1:0]];
                // Sticky flag keeps a back-pressured head eligible across timestamp wrap.
                assign age_ok = head_eligible || (age >= TS_W'(LATENCY));
                assign push   = q_in_valid[q] && !full;
                assign pop    = q_out_valid[q] && q_out_ready[q];

                assign q_in_ready[q]  = !full;
                assign q_out_valid[q] = !empty && age_ok && (gap_cnt == '0);
                assign q_out_data[q]  = data_mem[rd_ptr[AW-1:0]];
                assign q_busy[q]      = !empty;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        head_eligible <= 1'b0;
                        gap_cnt       <= '0;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
                        if (pop) begin
                            rd_ptr        <= rd_ptr + (AW+1)'(1);
                            head_eligible <= 1'b0;
                        end else if (!empty && age_ok) begin
                            head_eligible <= 1'b1;
                        end
                        if (pop)                  gap_cnt <= GW'(GAP);
                        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - GW'(1);
                    end
                end

                always_ff @(posedge clk) begin
                    if (push) begin
                        data_mem[wr_ptr[AW-1:0]] <= q_in_data[q];
                        ts_mem[wr_ptr[AW-1:0]]   <= now;
                    end
                end
            end

            // Sideband status delayed by LATENCY cycles to match the data path.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(LATENCY); i++) sb_pipe[i] <= '0;
                end else begin
                    sb_pipe[0] <= {downstream_has_odd_clusters, downstream_has_message_flying};
                    for (int i = 1; i < int'(LATENCY); i++) sb_pipe[i] <= sb_pipe[i-1];
                end
            end
            assign {upstream_has_odd_clusters, upstream_has_message_flying} = sb_pipe[LATENCY-1];
        end
    endgenerate

`ifdef LINK_STATS_EN
    function automatic logic [31:0] popcnt(input logic [CHANNELS-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < int'(CHANNELS); i++) s = s + 32'(v[i]);
        return s;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic stall_c;
    assign stall_c = |(downstream_fifo_out_valid & ~downstream_fifo_out_ready)
                   | |(upstream_fifo_out_valid   & ~upstream_fifo_out_ready)
                   | |(upstream_fifo_in_valid    & ~upstream_fifo_in_ready)
                   | |(downstream_fifo_in_valid  & ~downstream_fifo_in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_flits_down   <= '0;
            stat_flits_up     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_flits_down   <= sat_add(stat_flits_down,
                                         popcnt(downstream_fifo_out_valid & downstream_fifo_out_ready));
            stat_flits_up     <= sat_add(stat_flits_up,
                                         popcnt(upstream_fifo_out_valid & upstream_fifo_out_ready));
            stat_stall_cycles <= sat_add(stat_stall_cycles, 32'(stall_c));
        end
    end
`endif

endmodule

// File: tb/tb_interconnect_link_model.sv
// Self-checking bench for interconnect_link_model: directed scenarios plus random traffic
// compared every cycle against a cycle-indexed queue model of the link.
module tb_interconnect_link_model;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int L  = 3;
    localparam int D  = 4;
    localparam int G  = 1;
    localparam int TW = 4;
    localparam int NQ = 2 * C;
    localparam int MASK = (1 << TW) - 1;

    logic clk, reset;
    logic [W*C-1:0] upstream_fifo_in_data, downstream_fifo_out_data;
    logic [W*C-1:0] downstream_fifo_in_data, upstream_fifo_out_data;
    logic [C-1:0]   upstream_fifo_in_valid, upstream_fifo_in_ready;
    logic [C-1:0]   downstream_fifo_out_valid, downstream_fifo_out_ready;
    logic [C-1:0]   downstream_fifo_in_valid, downstream_fifo_in_ready;
    logic [C-1:0]   upstream_fifo_out_valid, upstream_fifo_out_ready;
    logic [C-1:0]   downstream_has_message_flying, downstream_has_odd_clusters;
    logic [C-1:0]   upstream_has_message_flying, upstream_has_odd_clusters;
    logic           link_busy;

    interconnect_link_model #(
        .WIDTH(W), .CHANNELS(C), .LATENCY(L), .DEPTH(D), .GAP(G), .TS_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .upstream_fifo_in_data(upstream_fifo_in_data),
        .upstream_fifo_in_valid(upstream_fifo_in_valid),
        .upstream_fifo_in_ready(upstream_fifo_in_ready),
        .downstream_fifo_out_data(downstream_fifo_out_data),
        .downstream_fifo_out_valid(downstream_fifo_out_valid),
        .downstream_fifo_out_ready(downstream_fifo_out_ready),
        .downstream_fifo_in_data(downstream_fifo_in_data),
        .downstream_fifo_in_valid(downstream_fifo_in_valid),
        .downstream_fifo_in_ready(downstream_fifo_in_ready),
        .upstream_fifo_out_data(upstream_fifo_out_data),
        .upstream_fifo_out_valid(upstream_fifo_out_valid),
        .upstream_fifo_out_ready(upstream_fifo_out_ready),
        .downstream_has_message_flying(downstream_has_message_flying),
        .downstream_has_odd_clusters(downstream_has_odd_clusters),
        .upstream_has_message_flying(upstream_has_message_flying),
        .upstream_has_odd_clusters(upstream_has_odd_clusters),
        .link_busy(link_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue q < C travels down, q >= C travels up.
    logic [NQ-1:0]   t_in_ready, t_out_valid;
    logic [NQ*W-1:0] t_out_data;
    assign t_in_ready  = {downstream_fifo_in_ready, upstream_fifo_in_ready};
    assign t_out_valid = {upstream_fifo_out_valid, downstream_fifo_out_valid};
    assign t_out_data  = {upstream_fifo_out_data, downstream_fifo_out_data};

    logic [W-1:0]   mq_data [NQ][$];
    int             mq_ts   [NQ][$];
    bit             sticky  [NQ];
    int             last_pop[NQ];
    logic [2*C-1:0] sb_hist [$];
    logic [C-1:0]   sb_odd, sb_fly;
    int n, n_pass, n_fail, n_total;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit elig(input int q);
        return sticky[q] || (((n - mq_ts[q][0]) & MASK) >= L);
    endfunction

    function automatic bit exp_valid(input int q);
        if (mq_data[q].size() == 0) return 1'b0;
        if (n - last_pop[q] <= G) return 1'b0;
        return elig(q);
    endfunction

    task automatic model_cycle(input logic [NQ-1:0] iv, input logic [NQ-1:0] ordy,
                               input logic [NQ*W-1:0] dat);
        logic [NQ-1:0] ev, er;
        logic [2*C-1:0] esb;
        bit busy;
        busy = 1'b0;
        for (int q = 0; q < NQ; q++) begin
            er[q] = (mq_data[q].size() < D);
            ev[q] = exp_valid(q);
            if (mq_data[q].size() != 0) busy = 1'b1;
        end
        esb = (n >= L) ? sb_hist[n-L] : '0;
        check("in_ready", 64'(t_in_ready), 64'(er));
        check("out_valid", 64'(t_out_valid), 64'(ev));
        check("link_busy", 64'(link_busy), 64'(busy));
        check("sideband", 64'({upstream_has_odd_clusters, upstream_has_message_flying}), 64'(esb));
        for (int q = 0; q < NQ; q++)
            if (ev[q]) check($sformatf("data_q%0d", q), 64'(t_out_data[q*W +: W]), 64'(mq_data[q][0]));
        for (int q = 0; q < NQ; q++) begin
            if (ev[q] && ordy[q]) begin
                void'(mq_data[q].pop_front());
                void'(mq_ts[q].pop_front());
                sticky[q]   = 1'b0;
                last_pop[q] = n;
            end else if (mq_data[q].size() != 0 && elig(q)) begin
                sticky[q] = 1'b1;
            end
            if (iv[q] && er[q]) begin
                mq_data[q].push_back(dat[q*W +: W]);
                mq_ts[q].push_back(n);
            end
        end
    endtask

    task automatic step(input logic [NQ-1:0] iv, input logic [NQ-1:0] ordy, input logic [NQ*W-1:0] dat);
        {downstream_fifo_in_valid, upstream_fifo_in_valid} = iv;
        {upstream_fifo_out_ready, downstream_fifo_out_ready} = ordy;
        {downstream_fifo_in_data, upstream_fifo_in_data} = dat;
        downstream_has_odd_clusters   = sb_odd;
        downstream_has_message_flying = sb_fly;
        sb_hist.push_back({sb_odd, sb_fly});
        #1;
        model_cycle(iv, ordy, dat);
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {downstream_fifo_in_valid, upstream_fifo_in_valid} = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        sb_hist.delete();
        for (int q = 0; q < NQ; q++) begin
            mq_data[q].delete();
            mq_ts[q].delete();
            sticky[q]   = 1'b0;
            last_pop[q] = -100;
        end
    endtask

    function automatic logic [NQ*W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NQ*W-1:0] one_flit(input int q, input logic [W-1:0] v);
        logic [NQ*W-1:0] d;
        d = '0;
        d[q*W +: W] = v;
        return d;
    endfunction

    initial begin
        int cnt;
        n_pass = 0; n_fail = 0; n_total = 0;
        reset = 1'b1;
        sb_odd = '0; sb_fly = '0;
        upstream_fifo_in_data = '0; downstream_fifo_in_data = '0;
        upstream_fifo_in_valid = '0; downstream_fifo_in_valid = '0;
        upstream_fifo_out_ready = '0; downstream_fifo_out_ready = '0;
        downstream_has_odd_clusters = '0; downstream_has_message_flying = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_valid", 64'(t_out_valid), 64'(0));
        check("rst_ready", 64'(t_in_ready), 64'(8'hFF));
        check("rst_busy", 64'(link_busy), 64'(0));
        check("rst_sideband", 64'({upstream_has_odd_clusters, upstream_has_message_flying}), 64'(0));

        // Single flit on down channel 1 appears exactly L cycles later.
        step(8'h02, 8'hFF, one_flit(1, 16'h00A5));
        for (int i = 0; i < L - 2; i++) step('0, 8'hFF, '0);
        check("lat_early", 64'(downstream_fifo_out_valid), 64'(0));
        step('0, 8'hFF, '0);
        check("lat_valid", 64'(downstream_fifo_out_valid), 64'(4'b0010));
        check("lat_data", 64'(downstream_fifo_out_data[31:16]), 64'(16'h00A5));
        step('0, 8'hFF, '0);
        step('0, 8'hFF, '0);

        // Fill queue 0, check ready drop, full push+pop rejects the push.
        for (int k = 1; k <= 4; k++) step(8'h01, 8'h00, one_flit(0, 16'(k)));
        check("full_ready", 64'(upstream_fifo_in_ready[0]), 64'(0));
        step(8'h01, 8'h00, one_flit(0, 16'd5));
        check("full_head_valid", 64'(downstream_fifo_out_valid[0]), 64'(1));
        step(8'h01, 8'hFF, one_flit(0, 16'd5));
        check("ready_after_pop", 64'(upstream_fifo_in_ready[0]), 64'(1));
        step(8'h01, 8'hFF, one_flit(0, 16'd5));
        for (int i = 0; i < 12; i++) step('0, 8'hFF, '0);

        // Throttle: with GAP=1 a full queue drains one flit every 2nd cycle.
        for (int k = 0; k < 4; k++) step(8'h20, 8'h00, one_flit(5, 16'(16'h100 + k)));
        for (int i = 0; i < 4; i++) step('0, 8'h00, '0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (upstream_fifo_out_valid[1]) cnt++;
            step('0, 8'hFF, '0);
        end
        check("gap_pops", 64'(cnt), 64'(3));
        for (int i = 0; i < 4; i++) step('0, 8'hFF, '0);

        // Held head survives timestamp wrap.
        step(8'h40, 8'h00, one_flit(6, 16'hBEEF));
        for (int i = 0; i < 40; i++) step('0, 8'h00, '0);
        check("wrap_valid", 64'(upstream_fifo_out_valid[2]), 64'(1));
        check("wrap_data", 64'(upstream_fifo_out_data[47:32]), 64'(16'hBEEF));
        step('0, 8'hFF, '0);
        check("wrap_popped", 64'(upstream_fifo_out_valid[2]), 64'(0));

        // Sideband toggle arrives L cycles later.
        sb_odd[2] = 1'b1;
        step('0, 8'hFF, '0);
        for (int i = 0; i < L - 2; i++) step('0, 8'hFF, '0);
        check("sb_before", 64'(upstream_has_odd_clusters[2]), 64'(0));
        step('0, 8'hFF, '0);
        check("sb_after", 64'(upstream_has_odd_clusters[2]), 64'(1));
        sb_odd = '0;

        // Reset with flits in flight discards them.
        step(8'h89, 8'h00, rnd_data());
        step('0, 8'h00, '0);
        do_reset();
        check("midrst_valid", 64'(t_out_valid), 64'(0));
        check("midrst_busy", 64'(link_busy), 64'(0));
        for (int i = 0; i < 2 * L; i++) step('0, 8'hFF, '0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sb_odd = C'($urandom);
                sb_fly = C'($urandom);
            end
            step(NQ'($urandom), NQ'($urandom | $urandom), rnd_data());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
